// File: rtl/mul_shift_add_if.sv
// Run/ready handshake bundle for the sequential shift-add multiplier.
interface mul_shift_add_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 run;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;
  logic                 ready;

  modport master (
    output run,
    output multiplicand,
    output multiplier,
    input  product,
    input  busy,
    input  ready
  );

  modport slave (
    input  run,
    input  multiplicand,
    input  multiplier,
    output product,
    output busy,
    output ready
  );
endinterface

// File: rtl/mul_shift_add.sv
// Sequential unsigned shift-add multiplier: one iteration per clock, WIDTH iterations per product.
module mul_shift_add #(
  parameter int unsigned WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  mul_shift_add_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;

  logic [WIDTH:0]       addend;
  logic [WIDTH:0]       sum;

  // Upper half plus the (optional) multiplicand; the extra bit keeps the carry.
  assign addend = prod_q[0] ? {1'b0, mcand_q} : '0;
  assign sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + addend;

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    unique case (state_q)
      StIdle: begin
        if (bus.run) begin
          mcand_d = bus.multiplicand;
          prod_d  = {{WIDTH{1'b0}}, bus.multiplier};
          cnt_d   = '0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        prod_d = {sum, prod_q[WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          busy_d  = 1'b0;
          ready_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        // No auto-restart: run must drop for a cycle to re-arm.
        if (!bus.run) begin
          ready_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign bus.product = prod_q;
  assign bus.busy    = busy_q;
  assign bus.ready   = ready_q;

endmodule
